color_calibrator: RTL and testbench
===================================

Name: color_calibrator

Overview:
- Sequences laser-color calibration ahead of painting.
- On a get_color press, averages camera pixels in a fixed square window over 2^FRAMES_LOG2 frames, latches the mean RGB as the reference color, then asserts run.
- Sits between the camera pixel stream and the laser-detect/paint datapath, which consumes ref_* and run.
- Supports re-calibration from RUN without a reset.

Parameters:
- CH_W, 8: bits per color channel.
- COORD_W, 10: pixel coordinate width.
- WIN_X0, 316: left column of the sample window.
- WIN_Y0, 236: top row of the sample window.
- WIN_LOG2, 3: window is 2^WIN_LOG2 x 2^WIN_LOG2 pixels (8x8).
- FRAMES_LOG2, 2: number of frames averaged is 2^FRAMES_LOG2 (4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low; clock clk.
- get_color  in  1  level from debounced key; only its rising edge acts.
- recal  in  1  single-cycle pulse; restart calibration from RUN.
- frame_start  in  1  single-cycle pulse at start of each camera frame.
- pix_valid  in  1  pix_* fields are valid this cycle.
- pix_x  in  COORD_W  pixel column.
- pix_y  in  COORD_W  pixel row.
- pix_r, pix_g, pix_b  in  CH_W each  pixel channels.
- ref_r, ref_g, ref_b  out  CH_W each  averaged reference color.
- ref_valid  out  1  ref_* holds a completed calibration.
- busy  out  1  high in ARM or ACCUM.
- cal_err  out  1  sticky; last calibration had a wrong sample count.
- run  out  1  high only in RUN.

Behaviour:
- Reset: state INITIALIZE. ref_* = 0, ref_valid = 0, busy = 0, cal_err = 0, run = 0. Accumulators and counters = 0. Reset wins over every other input, including mid-ACCUM.
- Edge detect: get_color is registered; go = get_color & ~get_color_q. A held key produces one go only.
- Window hit: WIN_X0 <= pix_x < WIN_X0 + 2^WIN_LOG2, and the same test on pix_y with WIN_Y0.
- Sample count: NS = 2^(2*WIN_LOG2 + FRAMES_LOG2). Accumulator width AW = CH_W + 2*WIN_LOG2 + FRAMES_LOG2; no overflow is possible. Sample counter width is AW - CH_W + 1.
- State INITIALIZE: go -> ARM. recal is ignored.
- State ARM: waits for frame_start. On frame_start -> ACCUM; clear acc_r/g/b, sample and frame counters. If pix_valid and a window hit occur in the same cycle, that pixel is accumulated: the frame_start clear is applied first. go and recal are ignored.
- State ACCUM:
  - Each cycle with pix_valid and a window hit: acc_c += pix_c for all three channels; sample_cnt += 1.
  - On frame_start: frame_cnt += 1.
  - When frame_start arrives with frame_cnt = 2^FRAMES_LOG2 - 1 (all frames done), evaluate the sample count:
    - sample_cnt == NS -> next cycle ref_c = acc_c >> (AW - CH_W), i.e. the top CH_W bits (truncating). ref_valid = 1, cal_err = 0, state RUN.
    - sample_cnt != NS -> cal_err = 1, state INITIALIZE. ref_* and ref_valid keep their previous values.
  - A pixel on the terminating frame_start cycle is not accumulated.
  - go and recal are ignored.
- State RUN: run = 1. recal -> ARM with run deasserted the next cycle. ref_* and ref_valid are retained until the new calibration completes. go is ignored.
- Outputs: all registered; run = (state == RUN), busy = (state == ARM || state == ACCUM).
- Latency: run rises 1 cycle after the final frame_start.

Decomposition:
- Package color_cal_pkg holds:
  - the state enum cal_state_t {INITIALIZE, ARM, ACCUM, RUN};
  - derived localparams AW and NS.
- One sub-module, cal_accum: a single-channel accumulator with clear and enable, instantiated three times.
- The FSM, window compare and counters live in the top module.

Test Plan:
- Constant color: pix = (0x40, 0x80, 0xC0) over the full window for 4 frames after go -> run rises 1 cycle after the 5th frame_start; ref = (0x40, 0x80, 0xC0); ref_valid = 1; cal_err = 0.
- Ramp: window pixel values vary 0..63 by position, identical in all 3 channels -> ref_c = floor(mean) = 31 for each channel.
- Missing pixels: drop one in-window pix_valid in frame 2 -> after the final frame_start, state INITIALIZE, cal_err = 1, ref_valid = 0, run = 0.
- Held key and out-of-window data: hold get_color high throughout and inject bright pixels outside the window -> exactly one calibration runs; out-of-window pixels do not change ref.
- Recal: in RUN with ref = (0x40, 0x80, 0xC0), pulse recal, then feed 0x10 pixels -> run = 0 and old ref retained during ARM/ACCUM; afterwards ref = (0x10, 0x10, 0x10) and run = 1.
- Reset mid-ACCUM: assert reset_n = 0 during frame 2 -> all outputs 0 next clock. A following go runs a clean calibration with the correct average.

Source files
------------

// File: rtl/color_cal_pkg.sv
// rtl/color_cal_pkg.sv - shared state encoding and derived sizes for the color calibrator
package color_cal_pkg;

  typedef enum logic [1:0] {
    INITIALIZE,
    ARM,
    ACCUM,
    RUN
  } cal_state_t;

  localparam int CH_W_DEF        = 8;
  localparam int WIN_LOG2_DEF    = 3;
  localparam int FRAMES_LOG2_DEF = 2;

  function automatic int acc_width(input int ch_w, input int win_log2, input int frames_log2);
    return ch_w + 2 * win_log2 + frames_log2;
  endfunction

  function automatic int num_samples(input int win_log2, input int frames_log2);
    return 1 << (2 * win_log2 + frames_log2);
  endfunction

  localparam int AW = acc_width(CH_W_DEF, WIN_LOG2_DEF, FRAMES_LOG2_DEF);
  localparam int NS = num_samples(WIN_LOG2_DEF, FRAMES_LOG2_DEF);

endpackage

// File: rtl/cal_accum.sv
// rtl/cal_accum.sv - single-channel sample accumulator with clear and enable
import color_cal_pkg::*;

module cal_accum #(
  parameter int CH_W  = CH_W_DEF,
  parameter int ACC_W = AW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CH_W-1:0]  din,
  output logic [ACC_W-1:0] acc
);

  // clear and en together load the sample, so a window pixel on the first frame_start counts
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= en ? ACC_W'(din) : '0;
    end else if (en) begin
      acc <= acc + ACC_W'(din);
    end
  end

endmodule

// File: rtl/color_calibrator.sv
// rtl/color_calibrator.sv - averages a fixed pixel window over several frames to latch the laser reference color
import color_cal_pkg::*;

module color_calibrator #(
  parameter int CH_W        = 8,
  parameter int COORD_W     = 10,
  parameter int WIN_X0      = 316,
  parameter int WIN_Y0      = 236,
  parameter int WIN_LOG2    = 3,
  parameter int FRAMES_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               get_color,
  input  logic               recal,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [CH_W-1:0]    pix_r,
  input  logic [CH_W-1:0]    pix_g,
  input  logic [CH_W-1:0]    pix_b,
  output logic [CH_W-1:0]    ref_r,
  output logic [CH_W-1:0]    ref_g,
  output logic [CH_W-1:0]    ref_b,
  output logic               ref_valid,
  output logic               busy,
  output logic               cal_err,
  output logic               run
);

  localparam int ACC_W = acc_width(CH_W, WIN_LOG2, FRAMES_LOG2);
  localparam int CNT_W = ACC_W - CH_W + 1;
  localparam int FC_W  = (FRAMES_LOG2 > 0) ? FRAMES_LOG2 : 1;

  localparam logic [CNT_W-1:0]   NS_CNT     = CNT_W'(num_samples(WIN_LOG2, FRAMES_LOG2));
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [FC_W-1:0]    LAST_FRAME = FC_W'((1 << FRAMES_LOG2) - 1);
  localparam logic [COORD_W:0]   X_LO       = (COORD_W + 1)'(WIN_X0);
  localparam logic [COORD_W:0]   X_HI       = (COORD_W + 1)'(WIN_X0 + (1 << WIN_LOG2));
  localparam logic [COORD_W:0]   Y_LO       = (COORD_W + 1)'(WIN_Y0);
  localparam logic [COORD_W:0]   Y_HI       = (COORD_W + 1)'(WIN_Y0 + (1 << WIN_LOG2));

  cal_state_t       state;
  logic             get_color_q;
  logic [CNT_W-1:0] sample_cnt;
  logic [FC_W-1:0]  frame_cnt;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_g;
  logic [ACC_W-1:0] acc_b;

  logic go;
  logic hit;
  logic last_frame;
  logic acc_clear;
  logic acc_en;

  always_comb begin
    go         = get_color & ~get_color_q;
    hit        = pix_valid &&
                 ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
                 ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
    last_frame = frame_start && (frame_cnt == LAST_FRAME);
    acc_clear  = (state == ARM) && frame_start;
    // the terminating frame_start closes the window, its pixel is dropped
    acc_en     = hit && (acc_clear || ((state == ACCUM) && !last_frame));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      get_color_q <= 1'b0;
    end else begin
      get_color_q <= get_color;
    end
  end

  cal_accum #(.CH_W(CH_W), .ACC_W(ACC_W)) u_acc_r (
    .clk(clk), .reset_n(reset_n), .clear(acc_clear), .en(acc_en), .din(pix_r), .acc(acc_r)
  );
  cal_accum #(.CH_W(CH_W), .ACC_W(ACC_W)) u_acc_g (
    .clk(clk), .reset_n(reset_n), .clear(acc_clear), .en(acc_en), .din(pix_g), .acc(acc_g)
  );
  cal_accum #(.CH_W(CH_W), .ACC_W(ACC_W)) u_acc_b (
    .clk(clk), .reset_n(reset_n), .clear(acc_clear), .en(acc_en), .din(pix_b), .acc(acc_b)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= INITIALIZE;
      sample_cnt <= '0;
      frame_cnt  <= '0;
      ref_r      <= '0;
      ref_g      <= '0;
      ref_b      <= '0;
      ref_valid  <= 1'b0;
      busy       <= 1'b0;
      cal_err    <= 1'b0;
      run        <= 1'b0;
    end else begin
      case (state)
        INITIALIZE: begin
          if (go) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (frame_start) begin
            state      <= ACCUM;
            frame_cnt  <= '0;
            sample_cnt <= hit ? CNT_W'(1) : '0;
          end
        end
        ACCUM: begin
          if (last_frame) begin
            busy <= 1'b0;
            if (sample_cnt == NS_CNT) begin
              ref_r     <= acc_r[ACC_W-1 -: CH_W];
              ref_g     <= acc_g[ACC_W-1 -: CH_W];
              ref_b     <= acc_b[ACC_W-1 -: CH_W];
              ref_valid <= 1'b1;
              cal_err   <= 1'b0;
              run       <= 1'b1;
              state     <= RUN;
            end else begin
              cal_err <= 1'b1;
              state   <= INITIALIZE;
            end
          end else begin
            if (frame_start) begin
              frame_cnt <= frame_cnt + 1'b1;
            end
            // saturate so a flood of extra samples can never wrap back to a valid count
            if (hit && (sample_cnt != CNT_MAX)) begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (recal) begin
            state <= ARM;
            run   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= INITIALIZE;
          busy  <= 1'b0;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_calibrator.sv
// tb/tb_color_calibrator.sv - randomized self-checking bench for color_calibrator against a window-average model
module tb_color_calibrator;

  localparam int WIN_X0 = 316;
  localparam int WIN_Y0 = 236;
  localparam int WIN_N  = 8;
  localparam int NFR    = 4;
  localparam int NS     = WIN_N * WIN_N * NFR;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       get_color;
  logic       recal;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic [7:0] ref_r;
  logic [7:0] ref_g;
  logic [7:0] ref_b;
  logic       ref_valid;
  logic       busy;
  logic       cal_err;
  logic       run;

  color_calibrator dut (
    .clk(clk), .reset_n(reset_n), .get_color(get_color), .recal(recal),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .ref_r(ref_r), .ref_g(ref_g), .ref_b(ref_b), .ref_valid(ref_valid),
    .busy(busy), .cal_err(cal_err), .run(run)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: sums of every in-window sample the bench delivered while calibrating
  int         sum_r, sum_g, sum_b, cnt;
  logic [7:0] e_r, e_g, e_b;
  logic       e_valid, e_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= WIN_X0) && (x < WIN_X0 + WIN_N) && (y >= WIN_Y0) && (y < WIN_Y0 + WIN_N);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fs, input bit v, input int x, input int y,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit count);
    frame_start = fs;
    pix_valid   = v;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    pix_r       = r;
    pix_g       = g;
    pix_b       = b;
    if (count && v && in_win(x, y)) begin
      sum_r += int'(r);
      sum_g += int'(g);
      sum_b += int'(b);
      cnt++;
    end
    tick();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
  endtask

  // bright pixels just outside the window edges, or invalid cycles inside it
  task automatic noise();
    int k;
    int o;
    k = $urandom_range(0, 3);
    o = $urandom_range(0, WIN_N - 1);
    case (k)
      0: drive(0, 1, WIN_X0 - 1, WIN_Y0 + o, 8'hFF, 8'hFF, 8'hFF, 1);
      1: drive(0, 1, WIN_X0 + WIN_N, WIN_Y0 + o, 8'hFF, 8'hFF, 8'hFF, 1);
      2: drive(0, 1, WIN_X0 + o, ($urandom_range(0, 1) != 0) ? WIN_Y0 - 1 : WIN_Y0 + WIN_N,
               8'hFF, 8'hFF, 8'hFF, 1);
      default: drive(0, 0, WIN_X0 + o, WIN_Y0 + o, 8'hFF, 8'hFF, 8'hFF, 1);
    endcase
  endtask

  task automatic pix_val(input int mode, input int i, output logic [7:0] r, output logic [7:0] g,
                         output logic [7:0] b);
    case (mode)
      0: begin r = 8'h40; g = 8'h80; b = 8'hC0; end
      1: begin r = 8'(i); g = 8'(i); b = 8'(i); end
      2: begin r = 8'h10; g = 8'h10; b = 8'h10; end
      default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
    endcase
  endtask

  task automatic check_ref(input string tag);
    check({tag, "_ref_r"}, 32'(ref_r), 32'(e_r));
    check({tag, "_ref_g"}, 32'(ref_g), 32'(e_g));
    check({tag, "_ref_b"}, 32'(ref_b), 32'(e_b));
    check({tag, "_ref_valid"}, 32'(ref_valid), 32'(e_valid));
  endtask

  task automatic send_frames(input int mode, input int nframes, input bit drop);
    logic [7:0] r, g, b;
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < WIN_N * WIN_N; i++) begin
        if (!(drop && f == 1 && i == 37)) begin
          pix_val(mode, i, r, g, b);
          drive(i == 0, 1, WIN_X0 + (i % WIN_N), WIN_Y0 + (i / WIN_N), r, g, b, 1);
          if ($urandom_range(0, 3) == 0) noise();
        end
      end
    end
  endtask

  // start: 0 = key press, 1 = recal pulse
  task automatic calibrate(input string tag, input bit start, input int mode, input bit drop,
                           input bit hold);
    if (!start) begin
      get_color = 1'b1;
      tick();
      if (!hold) get_color = 1'b0;
    end else begin
      recal = 1'b1;
      tick();
      recal = 1'b0;
    end
    check({tag, "_arm_busy"}, 32'(busy), 1);
    check({tag, "_arm_run"}, 32'(run), 0);
    sum_r = 0; sum_g = 0; sum_b = 0; cnt = 0;
    repeat (3) noise();
    send_frames(mode, NFR, drop);
    check({tag, "_accum_busy"}, 32'(busy), 1);
    check({tag, "_accum_run"}, 32'(run), 0);
    check_ref({tag, "_accum"});
    // terminating frame_start carries an uncounted bright window pixel
    drive(1, 1, WIN_X0, WIN_Y0, 8'hFF, 8'hFF, 8'hFF, 0);
    if (cnt == NS) begin
      e_r = 8'(sum_r / NS);
      e_g = 8'(sum_g / NS);
      e_b = 8'(sum_b / NS);
      e_valid = 1'b1;
      e_err   = 1'b0;
    end else begin
      e_err = 1'b1;
    end
    check({tag, "_done_run"}, 32'(run), 32'(!e_err));
    check({tag, "_done_busy"}, 32'(busy), 0);
    check({tag, "_done_err"}, 32'(cal_err), 32'(e_err));
    check_ref({tag, "_done"});
  endtask

  task automatic apply_reset();
    get_color = 1'b0;
    reset_n   = 1'b0;
    tick();
    reset_n = 1'b1;
    e_r = '0; e_g = '0; e_b = '0; e_valid = 1'b0; e_err = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_run"}, 32'(run), 0);
    check({tag, "_err"}, 32'(cal_err), 0);
    check_ref(tag);
  endtask

  initial begin
    reset_n = 1'b0; get_color = 1'b0; recal = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    pix_x = '0; pix_y = '0; pix_r = '0; pix_g = '0; pix_b = '0;
    repeat (3) tick();
    apply_reset();
    check_idle("reset");

    recal = 1'b1;
    tick();
    recal = 1'b0;
    tick();
    check("init_recal_ignored", 32'(busy), 0);

    calibrate("const", 0, 0, 0, 0);

    get_color = 1'b1;
    tick();
    get_color = 1'b0;
    repeat (2) tick();
    check("run_go_ignored_run", 32'(run), 1);
    check("run_go_ignored_busy", 32'(busy), 0);

    calibrate("recal10", 1, 2, 0, 0);
    calibrate("ramp", 1, 1, 0, 0);
    check("ramp_value", 32'(ref_r), 31);

    apply_reset();
    calibrate("drop", 0, 0, 1, 0);
    check("drop_state_idle", 32'(busy | run), 0);
    calibrate("after_drop", 0, 0, 0, 0);

    apply_reset();
    calibrate("held", 0, 3, 0, 1);
    repeat (6) noise();
    check("held_single_run", 32'(run), 1);
    check("held_single_busy", 32'(busy), 0);
    check_ref("held_after");
    get_color = 1'b0;
    tick();

    calibrate("recal_rand", 1, 3, 0, 0);

    // reset during frame 2 of an accumulation
    get_color = 1'b1;
    tick();
    get_color = 1'b0;
    sum_r = 0; sum_g = 0; sum_b = 0; cnt = 0;
    send_frames(3, 2, 0);
    apply_reset();
    get_color = 1'b0;
    check_idle("mid_reset");
    tick();
    calibrate("post_reset", 0, 3, 0, 0);

    calibrate("recal_drop", 1, 3, 1, 0);
    check("recal_drop_valid_kept", 32'(ref_valid), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
